// File: rtl/ex_branch_pipe_if.sv
// Issue-side and result-side handshake bundle for the branch/jump execution unit.
interface ex_branch_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_next;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [19:0]     imm_1231;
  logic [8:0]      inst_flags;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc_next_out;
  logic            jmp_en;
  logic            b_n_jmp;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] rd_data_out;
  logic            rd_out_en;
  logic            mispredict;

  modport master (
    output in_valid, pc_cur, pc_next, rd, rs1_data, rs2_data, imm_1231,
           inst_flags, pred_taken, pred_target, out_ready,
    input  in_ready, out_valid, pc_next_out, jmp_en, b_n_jmp, rd_out,
           rd_data_out, rd_out_en, mispredict
  );

  modport slave (
    input  in_valid, pc_cur, pc_next, rd, rs1_data, rs2_data, imm_1231,
           inst_flags, pred_taken, pred_target, out_ready,
    output in_ready, out_valid, pc_next_out, jmp_en, b_n_jmp, rd_out,
           rd_data_out, rd_out_en, mispredict
  );
endinterface

// File: rtl/ex_branch_pipe.sv
// Branch/jump/auipc resolution with one registered output stage, prediction
// check, 2-bit-counter branch history table and resolution statistics.
module ex_branch_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  ex_branch_pipe_if.slave      bus,
  input  logic [XLEN-1:0]      lk_pc,
  output logic                 lk_taken,
  output logic [31:0]          br_cnt,
  output logic [31:0]          misp_cnt
);
  localparam int unsigned BHT_N = 1 << BHT_IDX_W;

  logic [12:0]     off_b;
  logic [11:0]     off_i;
  logic [20:0]     off_j;
  logic [31:0]     off_u;
  logic [XLEN-1:0] imm_b, imm_i, imm_j, imm_u;
  logic [XLEN-1:0] jalr_sum;

  logic            is_cond, is_jump, cond;
  logic            n_jmp, n_bnj, n_en, n_misp;
  logic [XLEN-1:0] n_pc, n_data;
  logic [4:0]      n_rd;
  logic            accept;

  logic [1:0]      bht [BHT_N];
  logic [BHT_IDX_W-1:0] wr_idx, rd_idx;
  logic            unused_lk;

  assign off_b = {bus.imm_1231[19], bus.rd[0], bus.imm_1231[18:13], bus.rd[4:1], 1'b0};
  assign off_i = bus.imm_1231[19:8];
  assign off_j = {bus.imm_1231[19], bus.imm_1231[7:0], bus.imm_1231[8], bus.imm_1231[18:9], 1'b0};
  assign off_u = {bus.imm_1231, 12'b0};

  assign imm_b = XLEN'($signed(off_b));
  assign imm_i = XLEN'($signed(off_i));
  assign imm_j = XLEN'($signed(off_j));
  assign imm_u = XLEN'($signed(off_u));

  assign jalr_sum = bus.rs1_data + imm_i;

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Decode picks one instruction class by fixed priority, then branches and
  // jumps share the taken/link field assignment below the chain.
  always_comb begin
    is_cond = 1'b0;
    is_jump = 1'b0;
    cond    = 1'b0;
    n_pc    = bus.pc_next;
    n_jmp   = 1'b0;
    n_bnj   = 1'b0;
    n_rd    = '0;
    n_data  = '0;
    n_en    = 1'b0;
    n_misp  = 1'b0;

    if (bus.inst_flags[0]) begin
      is_cond = 1'b1;
      cond    = (bus.rs1_data == bus.rs2_data);
    end else if (bus.inst_flags[1]) begin
      is_cond = 1'b1;
      cond    = !($signed(bus.rs1_data) < $signed(bus.rs2_data));
    end else if (bus.inst_flags[2]) begin
      is_cond = 1'b1;
      cond    = !(bus.rs1_data < bus.rs2_data);
    end else if (bus.inst_flags[3]) begin
      is_cond = 1'b1;
      cond    = $signed(bus.rs1_data) < $signed(bus.rs2_data);
    end else if (bus.inst_flags[4]) begin
      is_cond = 1'b1;
      cond    = bus.rs1_data < bus.rs2_data;
    end else if (bus.inst_flags[5]) begin
      is_cond = 1'b1;
      cond    = (bus.rs1_data != bus.rs2_data);
    end else if (bus.inst_flags[6]) begin
      is_jump = 1'b1;
      n_pc    = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (bus.inst_flags[7]) begin
      is_jump = 1'b1;
      n_pc    = bus.pc_cur + imm_j;
    end else if (bus.inst_flags[8]) begin
      n_rd    = bus.rd;
      n_data  = bus.pc_cur + imm_u;
      n_en    = 1'b1;
    end

    if (is_cond) begin
      n_jmp = cond;
      n_bnj = !cond;
      if (cond) n_pc = bus.pc_cur + imm_b;
    end
    if (is_jump) begin
      n_jmp  = 1'b1;
      n_rd   = bus.rd;
      n_data = bus.pc_next;
      n_en   = 1'b1;
    end

    // A bubble reports nothing; any real instruction is checked against the prediction.
    if (|bus.inst_flags)
      n_misp = (n_jmp != bus.pred_taken) ||
               (n_jmp && bus.pred_taken && (n_pc != bus.pred_target));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid   <= 1'b0;
      bus.pc_next_out <= '0;
      bus.jmp_en      <= 1'b0;
      bus.b_n_jmp     <= 1'b0;
      bus.rd_out      <= '0;
      bus.rd_data_out <= '0;
      bus.rd_out_en   <= 1'b0;
      bus.mispredict  <= 1'b0;
    end else if (flush) begin
      bus.out_valid   <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.pc_next_out <= n_pc;
      bus.jmp_en      <= n_jmp;
      bus.b_n_jmp     <= n_bnj;
      bus.rd_out      <= n_rd;
      bus.rd_data_out <= n_data;
      bus.rd_out_en   <= n_en;
      bus.mispredict  <= n_misp;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt   <= '0;
      misp_cnt <= '0;
    end else if (accept && (is_cond || is_jump)) begin
      br_cnt <= br_cnt + 32'd1;
      if (n_misp) misp_cnt <= misp_cnt + 32'd1;
    end
  end

  assign wr_idx = bus.pc_cur[BHT_IDX_W+1:2];
  assign rd_idx = lk_pc[BHT_IDX_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (accept && is_cond) begin
      if (cond && (bht[wr_idx] != 2'b11))
        bht[wr_idx] <= bht[wr_idx] + 2'b01;
      else if (!cond && (bht[wr_idx] != 2'b00))
        bht[wr_idx] <= bht[wr_idx] - 2'b01;
    end
  end

  // Read straight from the table, so a same-cycle update shows up one cycle later.
  assign lk_taken  = bht[rd_idx][1];
  assign unused_lk = ^{lk_pc[1:0], lk_pc[XLEN-1:BHT_IDX_W+2]};

endmodule

// File: tb/tb_ex_branch_pipe.sv
// Directed bench for ex_branch_pipe: scoreboard of expected results checked as they leave.
module tb_ex_branch_pipe;
  typedef struct packed {
    logic [31:0] pc;
    logic        jmp;
    logic        bnj;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        en;
    logic        misp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] lk_pc = 32'h40;
  logic        lk_taken;
  logic [31:0] br_cnt, misp_cnt;

  int   total = 0;
  int   passed = 0;
  int   exp_br = 0;
  int   exp_misp = 0;
  int   last_wait = 0;
  logic lk_at_acc = 1'b0;
  res_t q[$];
  res_t sb_e;
  logic [24:0] eb;

  ex_branch_pipe_if #(.XLEN(32)) bus ();

  ex_branch_pipe #(.XLEN(32), .BHT_IDX_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .lk_pc    (lk_pc),
    .lk_taken (lk_taken),
    .br_cnt   (br_cnt),
    .misp_cnt (misp_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [24:0] enc_b(input logic [12:0] o);
    logic [19:0] im;
    im = '0;
    im[19]    = o[12];
    im[18:13] = o[10:5];
    return {im, o[4:1], o[11]};
  endfunction

  function automatic logic [19:0] enc_j(input logic [20:0] o);
    return {o[20], o[10:1], o[11], o[19:12]};
  endfunction

  function automatic res_t br_exp(input logic [31:0] pc, input logic [12:0] off,
                                  input logic pt, input logic [31:0] ptg, input logic tk);
    res_t e;
    logic [31:0] sx;
    sx     = {{19{off[12]}}, off};
    e.pc   = tk ? pc + sx : pc + 32'd4;
    e.jmp  = tk;
    e.bnj  = !tk;
    e.rd   = '0;
    e.data = '0;
    e.en   = 1'b0;
    e.misp = (tk != pt) || (tk && pt && (e.pc != ptg));
    return e;
  endfunction

  task automatic drive(input logic [8:0] fl, input logic [31:0] pc, rs1, rs2,
                       input logic [4:0] rdf, input logic [19:0] imm,
                       input logic pt, input logic [31:0] ptg);
    bus.inst_flags  = fl;
    bus.pc_cur      = pc;
    bus.pc_next     = pc + 32'd4;
    bus.rs1_data    = rs1;
    bus.rs2_data    = rs2;
    bus.rd          = rdf;
    bus.imm_1231    = imm;
    bus.pred_taken  = pt;
    bus.pred_target = ptg;
    bus.in_valid    = 1'b1;
  endtask

  task automatic wait_push(input res_t e, input bit ctd);
    bit ok = 0;
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    last_wait = k;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      lk_at_acc = lk_taken;
      q.push_back(e);
      if (ctd) begin
        exp_br++;
        if (e.misp) exp_misp++;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic br(input logic [8:0] fl, input logic [31:0] pc, rs1, rs2,
                    input logic [12:0] off, input logic pt, input logic [31:0] ptg,
                    input logic tk);
    logic [24:0] en;
    en = enc_b(off);
    drive(fl, pc, rs1, rs2, en[4:0], en[24:5], pt, ptg);
    wait_push(br_exp(pc, off, pt, ptg, tk), 1);
  endtask

  task automatic chk_cnt(input string tag);
    @(negedge clk);
    chk({tag, "_br_cnt"}, 64'(br_cnt), 64'(exp_br));
    chk({tag, "_misp_cnt"}, 64'(misp_cnt), 64'(exp_misp));
    @(posedge clk); #1;
  endtask

  task automatic lk_chk(input string tag, input logic exp);
    @(negedge clk);
    chk(tag, 64'(lk_taken), 64'(exp));
    @(posedge clk); #1;
  endtask

  // Scoreboard: every transferred result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        sb_e = q.pop_front();
        chk("pc_next_out", 64'(bus.pc_next_out), 64'(sb_e.pc));
        chk("rd_data_out", 64'(bus.rd_data_out), 64'(sb_e.data));
        chk("ctl{jmp,bnj,rd,en,misp}",
            64'({bus.jmp_en, bus.b_n_jmp, bus.rd_out, bus.rd_out_en, bus.mispredict}),
            64'({sb_e.jmp, sb_e.bnj, sb_e.rd, sb_e.en, sb_e.misp}));
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.inst_flags = '0;
    bus.pc_cur = '0; bus.pc_next = '0; bus.rd = '0; bus.rs1_data = '0;
    bus.rs2_data = '0; bus.imm_1231 = '0; bus.pred_taken = 1'b0; bus.pred_target = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_pc_next_out", 64'(bus.pc_next_out), 64'd0);
    chk("rst_rd_data_out", 64'(bus.rd_data_out), 64'd0);
    chk("rst_lk_taken", 64'(lk_taken), 64'd0);
    chk("rst_br_cnt", 64'(br_cnt), 64'd0);
    chk("rst_misp_cnt", 64'(misp_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Main function: every conditional kind, jumps, auipc, bubble, priority.
    br(9'h001, 32'h100, 32'd5, 32'd5, 13'd16, 1'b0, 32'h0, 1'b1);
    chk_cnt("beq");
    br(9'h008, 32'h200, 32'hFFFF_FFFF, 32'd1, 13'd16, 1'b1, 32'h210, 1'b1);
    br(9'h010, 32'h204, 32'hFFFF_FFFF, 32'd1, 13'd16, 1'b0, 32'h0, 1'b0);
    br(9'h002, 32'h208, 32'hFFFF_FFFF, 32'd1, 13'd16, 1'b0, 32'h0, 1'b0);
    br(9'h004, 32'h20C, 32'hFFFF_FFFF, 32'd1, 13'd16, 1'b1, 32'h300, 1'b1);
    br(9'h020, 32'h210, 32'd1, 32'd2, 13'd16, 1'b1, 32'h220, 1'b1);
    drive(9'h040, 32'h400, 32'h2003, 32'h0, 5'd5, {12'd4, 8'h00}, 1'b1, 32'h2006);
    wait_push('{32'h2006, 1'b1, 1'b0, 5'd5, 32'h404, 1'b1, 1'b0}, 1);
    drive(9'h080, 32'h1000, 32'h0, 32'h0, 5'd1, enc_j(21'h1F_FFF8), 1'b0, 32'h0);
    wait_push('{32'hFF8, 1'b1, 1'b0, 5'd1, 32'h1004, 1'b1, 1'b1}, 1);
    drive(9'h100, 32'h3000, 32'h0, 32'h0, 5'd7, 20'h12345, 1'b0, 32'h0);
    wait_push('{32'h3004, 1'b0, 1'b0, 5'd7, 32'h1234_8000, 1'b1, 1'b0}, 0);
    drive(9'h000, 32'h500, 32'd1, 32'd2, 5'd9, 20'hABCDE, 1'b0, 32'h0);
    wait_push('{32'h504, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0}, 0);
    br(9'h081, 32'h600, 32'd1, 32'd2, 13'd16, 1'b0, 32'h0, 1'b0);
    chk_cnt("mix");

    // BHT training at pc 0x40: saturate up, then down, then one step back.
    lk_pc = 32'h40;
    lk_chk("bht_init", 1'b0);
    br(9'h001, 32'h40, 32'd3, 32'd3, 13'd16, 1'b0, 32'h0, 1'b1);
    chk("bht_same_cycle_read", 64'(lk_at_acc), 64'd0);
    lk_chk("bht_t1", 1'b1);
    br(9'h001, 32'h40, 32'd3, 32'd3, 13'd16, 1'b0, 32'h0, 1'b1);
    br(9'h001, 32'h40, 32'd3, 32'd3, 13'd16, 1'b0, 32'h0, 1'b1);
    br(9'h001, 32'h40, 32'd3, 32'd3, 13'd16, 1'b0, 32'h0, 1'b1);
    lk_chk("bht_t4_sat", 1'b1);
    br(9'h001, 32'h40, 32'd3, 32'd4, 13'd16, 1'b0, 32'h0, 1'b0);
    lk_chk("bht_nt1", 1'b1);
    br(9'h001, 32'h40, 32'd3, 32'd4, 13'd16, 1'b0, 32'h0, 1'b0);
    lk_chk("bht_nt2", 1'b0);
    br(9'h001, 32'h40, 32'd3, 32'd4, 13'd16, 1'b0, 32'h0, 1'b0);
    br(9'h001, 32'h40, 32'd3, 32'd4, 13'd16, 1'b0, 32'h0, 1'b0);
    lk_chk("bht_nt4", 1'b0);
    br(9'h001, 32'h40, 32'd3, 32'd3, 13'd16, 1'b0, 32'h0, 1'b1);
    lk_chk("bht_floor", 1'b0);
    chk_cnt("bht");

    // Backpressure: held result, stalled input, then one result per cycle.
    bus.out_ready = 1'b0;
    br(9'h001, 32'h700, 32'd1, 32'd1, 13'd16, 1'b0, 32'h0, 1'b1);
    eb = enc_b(13'd16);
    drive(9'h020, 32'h704, 32'd1, 32'd2, eb[4:0], eb[24:5], 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_pc_hold", 64'(bus.pc_next_out), 64'h710);
      chk("stall_br_cnt", 64'(br_cnt), 64'(exp_br));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_push(br_exp(32'h704, 13'd16, 1'b0, 32'h0, 1'b1), 1);
    chk("release_wait", 64'(last_wait), 64'd0);
    br(9'h001, 32'h708, 32'd1, 32'd2, 13'd16, 1'b0, 32'h0, 1'b0);
    chk("tput_wait1", 64'(last_wait), 64'd0);
    br(9'h008, 32'h70C, 32'd1, 32'd2, 13'd16, 1'b0, 32'h0, 1'b1);
    chk("tput_wait2", 64'(last_wait), 64'd0);
    chk_cnt("stall");

    // Flush with a held result and a competing instruction.
    bus.out_ready = 1'b0;
    br(9'h001, 32'h800, 32'd1, 32'd1, 13'd16, 1'b0, 32'h0, 1'b1);
    lk_pc = 32'h80;
    drive(9'h001, 32'h80, 32'd1, 32'd1, eb[4:0], eb[24:5], 1'b0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_br_cnt", 64'(br_cnt), 64'(exp_br));
    chk("flush_misp_cnt", 64'(misp_cnt), 64'(exp_misp));
    chk("flush_bht", 64'(lk_taken), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // Asynchronous reset while a result is held.
    bus.out_ready = 1'b0;
    lk_pc = 32'h100;
    br(9'h001, 32'h900, 32'd1, 32'd1, 13'd16, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    chk("pre_rst_lk", 64'(lk_taken), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_pc_next_out", 64'(bus.pc_next_out), 64'd0);
    chk("arst_ctl", 64'({bus.jmp_en, bus.rd_out_en, bus.mispredict}), 64'd0);
    chk("arst_br_cnt", 64'(br_cnt), 64'd0);
    chk("arst_misp_cnt", 64'(misp_cnt), 64'd0);
    chk("arst_lk", 64'(lk_taken), 64'd0);
    q.delete();
    exp_br = 0;
    exp_misp = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    br(9'h001, 32'h100, 32'd5, 32'd5, 13'd16, 1'b0, 32'h0, 1'b1);
    chk_cnt("post_rst");

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
